// File: rtl/control_pipe_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : control_pipe_unit_pkg
//  Description : Shared opcode encodings, control-bundle widths and bit
//                positions, plus the helper that tells whether an opcode
//                reads its rt field as a source operand. Reused by the
//                decoder, the hazard logic and ALU control.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_pipe_unit_pkg;

  // Bundle widths
  localparam int EX_W  = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  // EX bundle bit positions: [3] reg_dst, [2:1] alu_op, [0] alu_src
  localparam int EX_REG_DST = 3;
  localparam int EX_ALU_HI  = 2;
  localparam int EX_ALU_LO  = 1;
  localparam int EX_ALU_SRC = 0;

  // MEM bundle bit positions
  localparam int MEM_READ   = 2;
  localparam int MEM_WRITE  = 1;
  localparam int MEM_BRANCH = 0;

  // WB bundle bit positions
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // ALU operation class carried in ex[2:1]
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Opcodes whose rt field is a source register (and so can hit a load-use).
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_pipe_unit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : control_decoder
//  Description : Purely combinational opcode decoder producing the EX, MEM
//                and WB control bundles and an illegal-opcode flag. Unknown
//                opcodes decode to all-zero bundles.
//  Ports       : i_opcode  in  SIZEOP  instruction opcode
//                o_ex      out 4       reg_dst, alu_op[1:0], alu_src
//                o_mem     out 3       mem_read, mem_write, branch
//                o_wb      out 2       reg_write, mem_to_reg
//                o_illegal out 1       opcode not recognised
//  Revision    : 1.0 - initial release
// ============================================================================
module control_decoder
  import control_pipe_unit_pkg::*;
#(
  parameter int SIZEOP = 6
) (
  input  logic [SIZEOP-1:0] i_opcode,
  output logic [EX_W-1:0]   o_ex,
  output logic [MEM_W-1:0]  o_mem,
  output logic [WB_W-1:0]   o_wb,
  output logic              o_illegal
);

  always_comb begin
    o_ex      = '0;
    o_mem     = '0;
    o_wb      = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      SIZEOP'(OP_RTYPE): begin
        o_ex = {1'b1, ALU_FUNCT, 1'b0};
        o_wb = 2'b10;
      end
      SIZEOP'(OP_LW): begin
        o_ex  = {1'b0, ALU_ADD, 1'b1};
        o_mem = 3'b100;
        o_wb  = 2'b11;
      end
      SIZEOP'(OP_SW): begin
        o_ex  = {1'b0, ALU_ADD, 1'b1};
        o_mem = 3'b010;
      end
      SIZEOP'(OP_BEQ): begin
        o_ex  = {1'b0, ALU_SUB, 1'b0};
        o_mem = 3'b001;
      end
      SIZEOP'(OP_ADDI), SIZEOP'(OP_ANDI), SIZEOP'(OP_ORI),
      SIZEOP'(OP_XORI), SIZEOP'(OP_LUI),  SIZEOP'(OP_SLTI): begin
        o_ex = {1'b0, ALU_IMM, 1'b1};
        o_wb = 2'b10;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_pipe_unit
//  Description : Decodes the ID-stage instruction, carries the control
//                bundles through ID/EX, EX/MEM and MEM/WB, and detects
//                load-use hazards against the instruction held in ID/EX.
//  Ports       : i_clk          in  1          clock
//                i_rst_n        in  1          async active-low reset
//                i_instruccion  in  DATA_WIDTH ID instruction
//                i_valid        in  1          instruction valid
//                i_flush        in  1          kill instruction entering ID/EX
//                o_ex           out 4          EX bundle (ID/EX)
//                o_mem          out 3          MEM bundle (EX/MEM)
//                o_wb           out 2          WB bundle (MEM/WB)
//                o_stall        out 1          load-use hazard (combinational)
//                o_illegal      out 1          last accepted opcode undecoded
//                o_stall_count  out CNT_WIDTH  saturating stall-cycle count
//  Revision    : 1.0 - initial release
// ============================================================================
module control_pipe_unit
  import control_pipe_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIZEOP     = 6,
  parameter int NREG_BITS  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_instruccion,
  input  logic                  i_valid,
  input  logic                  i_flush,
  output logic [EX_W-1:0]       o_ex,
  output logic [MEM_W-1:0]      o_mem,
  output logic [WB_W-1:0]       o_wb,
  output logic                  o_stall,
  output logic                  o_illegal,
  output logic [CNT_WIDTH-1:0]  o_stall_count
);

  logic [SIZEOP-1:0]    w_opcode;
  logic [NREG_BITS-1:0] w_rs;
  logic [NREG_BITS-1:0] w_rt;
  ctrl_t                w_dec;
  logic                 w_dec_illegal;
  logic                 w_stall;
  logic                 unused_instr_bits;

  assign w_opcode = i_instruccion[DATA_WIDTH-1 -: SIZEOP];
  assign w_rs     = i_instruccion[21 +: NREG_BITS];
  assign w_rt     = i_instruccion[16 +: NREG_BITS];
  assign unused_instr_bits = ^i_instruccion[15:0];

  control_decoder #(.SIZEOP(SIZEOP)) u_decoder (
    .i_opcode  (w_opcode),
    .o_ex      (w_dec.ex),
    .o_mem     (w_dec.mem),
    .o_wb      (w_dec.wb),
    .o_illegal (w_dec_illegal)
  );

  // Pipeline state
  ctrl_t                idex_ctrl_q,  idex_ctrl_d;
  logic [NREG_BITS-1:0] idex_rt_q,    idex_rt_d;
  logic                 idex_valid_q, idex_valid_d;
  logic [MEM_W-1:0]     exmem_mem_q;
  logic [WB_W-1:0]      exmem_wb_q;
  logic [WB_W-1:0]      memwb_wb_q;
  logic                 illegal_q,    illegal_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q,  stall_cnt_d;

  // Load in ID/EX whose destination (rt) is read by the ID instruction.
  // rt only counts as a source for opcodes that actually read it; $0 never
  // carries a dependency.
  assign w_stall = i_valid & idex_valid_q & idex_ctrl_q.mem[MEM_READ] &
                   (idex_rt_q != '0) &
                   ((idex_rt_q == w_rs) |
                    ((idex_rt_q == w_rt) & reads_rt(6'(w_opcode))));

  always_comb begin
    idex_ctrl_d  = CTRL_NOP;
    idex_rt_d    = '0;
    idex_valid_d = 1'b0;
    illegal_d    = 1'b0;
    stall_cnt_d  = stall_cnt_q;
    // Flush, stall and invalid slots all insert a bubble.
    if (i_valid && !i_flush && !w_stall) begin
      idex_ctrl_d  = w_dec;
      idex_rt_d    = w_rt;
      idex_valid_d = 1'b1;
      illegal_d    = w_dec_illegal;
    end
    // Counts every stalled cycle, including ones that are also flushed.
    if (w_stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idex_ctrl_q  <= CTRL_NOP;
      idex_rt_q    <= '0;
      idex_valid_q <= 1'b0;
      exmem_mem_q  <= '0;
      exmem_wb_q   <= '0;
      memwb_wb_q   <= '0;
      illegal_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rt_q    <= idex_rt_d;
      idex_valid_q <= idex_valid_d;
      exmem_mem_q  <= idex_ctrl_q.mem;
      exmem_wb_q   <= idex_ctrl_q.wb;
      memwb_wb_q   <= exmem_wb_q;
      illegal_q    <= illegal_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign o_ex          = idex_ctrl_q.ex;
  assign o_mem         = exmem_mem_q;
  assign o_wb          = memwb_wb_q;
  assign o_stall       = w_stall;
  assign o_illegal     = illegal_q;
  assign o_stall_count = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_control_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_pipe_unit
//  Description : Self-checking bench for control_pipe_unit. A history-based
//                reference model predicts every output; a second instance
//                with a 2-bit stall counter exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_pipe_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        valid;
  logic        flush;

  logic [3:0]  ex,  ex2;
  logic [2:0]  mem, mem2;
  logic [1:0]  wb,  wb2;
  logic        stall, stall2, ill, ill2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int errors = 0;
  int checks = 0;

  control_pipe_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instruccion(instr), .i_valid(valid),
    .i_flush(flush), .o_ex(ex), .o_mem(mem), .o_wb(wb), .o_stall(stall),
    .o_illegal(ill), .o_stall_count(cnt)
  );

  control_pipe_unit #(.CNT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_instruccion(instr), .i_valid(valid),
    .i_flush(flush), .o_ex(ex2), .o_mem(mem2), .o_wb(wb2), .o_stall(stall2),
    .o_illegal(ill2), .o_stall_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each entry is what entered ID/EX at one clock edge; the newest entry
  // drives o_ex, the one before drives o_mem, the one before that o_wb.
  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic [4:0] rt;
    logic       v;
  } ent_t;

  ent_t hist[$];
  ent_t m_e, m_drop;
  int   m_cnt16, m_cnt2;
  logic m_ill, m_last_stall;
  logic [9:0] m_d;
  logic m_st;

  // {illegal, ex, mem, wb} straight from the decode table
  function automatic logic [9:0] spec_decode(input logic [5:0] op);
    case (op)
      6'h00:                                    return {1'b0, 4'b1100, 3'b000, 2'b10};
      6'h23:                                    return {1'b0, 4'b0001, 3'b100, 2'b11};
      6'h2B:                                    return {1'b0, 4'b0001, 3'b010, 2'b00};
      6'h04:                                    return {1'b0, 4'b0010, 3'b001, 2'b00};
      6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A: return {1'b0, 4'b0111, 3'b000, 2'b10};
      default:                                  return {1'b1, 9'b0};
    endcase
  endfunction

  function automatic logic m_stall();
    logic [5:0] op;
    op = instr[31:26];
    return valid && hist[0].v && hist[0].mem[2] && (hist[0].rt != 5'd0) &&
           ((hist[0].rt == instr[25:21]) ||
            ((hist[0].rt == instr[20:16]) && (op == 6'h00 || op == 6'h2B || op == 6'h04)));
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back('0);
    m_cnt16 = 0;
    m_cnt2 = 0;
    m_ill = 1'b0;
    m_last_stall = 1'b0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_d = spec_decode(instr[31:26]);
      m_st = m_stall();
      if (flush || m_st || !valid) m_e = '0;
      else m_e = '{ex: m_d[8:5], mem: m_d[4:2], wb: m_d[1:0], rt: instr[20:16], v: 1'b1};
      m_ill = valid && !flush && !m_st && m_d[9];
      if (m_st && m_cnt16 < 65535) m_cnt16++;
      if (m_st && m_cnt2 < 3) m_cnt2++;
      m_last_stall = m_st;
      hist.push_front(m_e);
      m_drop = hist.pop_back();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("ex",      {28'b0, ex},    {28'b0, hist[0].ex});
    chk("mem",     {29'b0, mem},   {29'b0, hist[1].mem});
    chk("wb",      {30'b0, wb},    {30'b0, hist[2].wb});
    chk("stall",   {31'b0, stall}, {31'b0, m_stall()});
    chk("illegal", {31'b0, ill},   {31'b0, m_ill});
    chk("count",   {16'b0, cnt},   m_cnt16);
    chk("count2",  {30'b0, cnt2},  m_cnt2);
    chk("ex2",     {19'b0, ex2, mem2, wb2, stall2, ill2},
                   {19'b0, hist[0].ex, hist[1].mem, hist[2].wb, m_stall(), m_ill});
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] ADD    = 32'h012A4020;
  localparam logic [31:0] LW8    = 32'h8C080000;
  localparam logic [31:0] ADD_R8 = 32'h010A4820;
  localparam logic [31:0] LW0    = 32'h8C000000;
  localparam logic [31:0] ADD_R0 = 32'h00004020;
  localparam logic [31:0] ADDI8  = 32'h20280005;
  localparam logic [31:0] SW8    = 32'hAC080000;
  localparam logic [31:0] BEQ    = 32'h11090002;
  localparam logic [31:0] BADOP  = 32'hFC000000;

  task automatic set_in(input logic [31:0] i, input logic v, input logic f);
    instr = i;
    valid = v;
    flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex"},  {28'b0, ex},  32'h0);
    chk({tag, "_mem"}, {29'b0, mem}, 32'h0);
    chk({tag, "_wb"},  {30'b0, wb},  32'h0);
    chk({tag, "_stall_ill"}, {30'b0, stall, ill}, 32'h0);
    chk({tag, "_cnt"}, {14'b0, cnt2, cnt}, 32'h0);
  endtask

  logic [5:0] ops [12] = '{6'h00, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h08,
                           6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h3F};

  initial begin
    rst_n = 1'b0;
    set_in(32'h0, 1'b0, 1'b0);
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // ADD latency through the three stages
    set_in(ADD, 1'b1, 1'b0);
    tick();
    chk("add_ex", {28'b0, ex}, 32'hC);
    set_in(32'h0, 1'b0, 1'b0);
    tick();
    chk("add_mem_ex", {25'b0, mem, ex}, 32'h0);
    chk("add_wb_early", {30'b0, wb}, 32'h0);
    tick();
    chk("add_wb", {30'b0, wb}, 32'h2);

    // LW $8 then dependent ADD: one stall, bubble, then proceeds
    set_in(LW8, 1'b1, 1'b0);
    #1 chk("lw_nostall", {31'b0, stall}, 32'h0);
    tick();
    chk("lw_ex", {28'b0, ex}, 32'h1);
    set_in(ADD_R8, 1'b1, 1'b0);
    #1 chk("lu_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("lu_bubble", {28'b0, ex}, 32'h0);
    chk("lu_cnt", {16'b0, cnt}, 32'h1);
    chk("lu_mem", {29'b0, mem}, 32'h4);
    chk("lu_nostall2", {31'b0, stall}, 32'h0);
    tick();
    chk("lu_ex", {28'b0, ex}, 32'hC);
    chk("lu_wb", {30'b0, wb}, 32'h3);

    // LW $0 never causes a hazard
    set_in(LW0, 1'b1, 1'b0);
    tick();
    set_in(ADD_R0, 1'b1, 1'b0);
    #1 chk("r0_stall", {31'b0, stall}, 32'h0);
    tick();

    // ADDI writes rt (no hazard); SW reads rt (hazard)
    set_in(LW8, 1'b1, 1'b0);
    tick();
    set_in(ADDI8, 1'b1, 1'b0);
    #1 chk("addi_stall", {31'b0, stall}, 32'h0);
    tick();
    set_in(LW8, 1'b1, 1'b0);
    tick();
    set_in(SW8, 1'b1, 1'b0);
    #1 chk("sw_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("sw_cnt", {16'b0, cnt}, 32'h2);
    tick();
    chk("sw_ex", {28'b0, ex}, 32'h1);

    // Flushed BEQ and illegal opcode
    set_in(BEQ, 1'b1, 1'b1);
    tick();
    chk("flush_ex_ill", {27'b0, ex, ill}, 32'h0);
    set_in(32'h0, 1'b0, 1'b0);
    tick();
    chk("flush_mem", {29'b0, mem}, 32'h0);
    tick();
    chk("flush_wb", {30'b0, wb}, 32'h0);
    set_in(BADOP, 1'b1, 1'b0);
    tick();
    chk("illegal", {31'b0, ill}, 32'h1);
    chk("illegal_ex", {28'b0, ex}, 32'h0);
    set_in(32'h0, 1'b0, 1'b0);
    tick();
    chk("illegal_clr", {31'b0, ill}, 32'h0);

    // Five more stalls: 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      set_in(LW8, 1'b1, 1'b0);
      tick();
      set_in(ADD_R8, 1'b1, 1'b0);
      tick();
    end
    chk("sat_cnt2", {30'b0, cnt2}, 32'h3);
    chk("sat_cnt16", {16'b0, cnt}, 32'h7);

    // Asynchronous reset mid-cycle clears everything at once
    set_in(LW8, 1'b1, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_in(ADD, 1'b1, 1'b0);
    tick();
    chk("post_rst_ex", {28'b0, ex}, 32'hC);

    // Randomized traffic; upstream holds the instruction while stalled
    for (int n = 0; n < 3000; n++) begin
      if (!m_last_stall || $urandom_range(0, 9) == 0) begin
        instr = {ops[$urandom_range(0, 11)], 3'b000, 2'($urandom_range(0, 3)),
                 3'b000, 2'($urandom_range(0, 3)), 16'($urandom)};
        if ($urandom_range(0, 15) == 0) instr[31:26] = 6'($urandom);
        valid = ($urandom_range(0, 9) < 8);
      end
      flush = ($urandom_range(0, 9) == 0);
      tick();
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rand_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
